seg7_multi_ctrl: RTL
====================

// Module: seg7_multi_ctrl
// PURPOSE
//  Parametrised N-digit seven-segment controller; Avalon-MM slave on the HPS lightweight bridge.
//  Per digit: hex-decode or raw segment mode, decimal point, blank and blink masks.
//  Drives the flat segment conduit (NUM_DIGITS*8 bits) to the board HEX displays.
//  Blink is driven by a programmable-period phase counter.
// PARAMETERS
//  NUM_DIGITS      6           digits driven, 1..8
//  SEG_ACTIVE_LOW  1           1: invert segment outputs at the pin (lit = 0)
//  BLINK_DIV       25000000    reset value of the PERIOD register, in clk cycles per half-period
// PORTS
//  clk             in   1              system clock
//  reset_n         in   1              async active-low reset
//  avs_address     in   4              word address
//  avs_write       in   1              write strobe
//  avs_writedata   in   32             write data
//  avs_read        in   1              read strobe
//  avs_readdata    out  32             read data, valid 1 cycle after avs_read
//  seg_out         out  NUM_DIGITS*8   digit i at [8i+7:8i] = {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  Clocking/reset: one clock domain; reset is asynchronous, active-low. All regs clear on reset_n=0, including mid-transfer.
//  Register map (32-bit words):
//   0..NUM_DIGITS-1  DIGIT[i]  [3:0] hex, [6:0] raw segs, [7] dp, [8] RAW (1=raw, 0=hex decode); reset 0
//   8                CTRL      [7:0] blank mask, [15:8] blink mask, [16] EN; reset 0
//   9                PERIOD    [31:0] blink half-period; reset BLINK_DIV
//   10               STATUS    [0] blink phase (RO)
//  Writes:
//   - Take effect at the clock edge where avs_write=1; zero wait states.
//   - Mask bits at or above NUM_DIGITS are stored but have no effect.
//   - Writes to undefined addresses and to STATUS are ignored.
//  Reads:
//   - readdata is registered: fixed latency 1, no waitrequest.
//   - Undefined addresses read 0. Unused bits read 0.
//   - readdata holds its value when avs_read=0.
//  Hex decode, active-high:
//   0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//  Segment image per digit: seg = RAW ? d[6:0] : dec(d[3:0]); dp = d[7].
//   - Forced all-off if EN=0, or blank[i]=1, or (blink[i]=1 and phase=0).
//  seg_out is registered:
//   - Updates 1 cycle after the edge that changed any register or phase (2 edges from the write strobe).
//   - Inverted when SEG_ACTIVE_LOW=1.
//   - Reset value: all segments off (all 1s when active-low, else all 0s).
//  Blink counter (32 bit): counts 0..PERIOD-1.
//   - At PERIOD-1: wraps to 0 and phase toggles.
//   - phase resets to 1 (visible).
//   - PERIOD=0: counter held at 0, phase forced 1.
//   - PERIOD write: counter cleared to 0, phase unchanged; this has priority over a wrap in the same cycle.
//   - Write to CTRL/DIGIT coincident with a wrap: both apply on that edge.
// TESTING
//  1. Reset, active-low, 6 digits -> seg_out=48'hFFFF_FFFF_FFFF; readdata=0; STATUS=1.
//  2. DIGIT0=0x00A, CTRL=0x10000 -> 2 edges later seg_out[7:0]=~8'h77=8'h88; other digits 8'hC0 ("0").
//  3. DIGIT1=0x1B6 (RAW, dp, segs 0x36) -> seg_out[15:8]=~8'hB6=8'h49; read DIGIT1 -> 0x1B6 one cycle after avs_read.
//  4. PERIOD=4, CTRL=0x10200 -> digit1 toggles every 4 clk; STATUS[0] alternates; PERIOD=0 -> digit1 steady on.
//  5. PERIOD write on the same cycle as a wrap -> counter=0, phase unchanged; read addr 12 -> 0; write addr 10 -> no change.
//  6. Assert reset_n mid-blink with EN=1 -> seg_out all-off immediately; PERIOD reads BLINK_DIV after release.

Source files
------------

// File: rtl/seg7_multi_ctrl.sv
// N-digit seven-segment controller with an Avalon-MM register slave.
// Per-digit hex/raw image with decimal point, blank and blink masks, registered segment outputs.
module seg7_multi_ctrl #(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter logic [31:0] BLINK_DIV      = 32'd25000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                avs_address,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  input  logic                      avs_read,
  output logic [31:0]               avs_readdata,
  output logic [NUM_DIGITS*8-1:0]   seg_out
);

  localparam int unsigned   SEG_W       = NUM_DIGITS * 8;
  localparam logic [3:0]    ADDR_CTRL   = 4'd8;
  localparam logic [3:0]    ADDR_PERIOD = 4'd9;
  localparam logic [3:0]    ADDR_STATUS = 4'd10;
  localparam logic [SEG_W-1:0] SEG_OFF  = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic [8:0]       digit_q [NUM_DIGITS];
  logic [7:0]       blank_q;
  logic [7:0]       blink_q;
  logic             en_q;
  logic [31:0]      period_q;
  logic [31:0]      cnt_q;
  logic             phase_q;

  logic             wr_ctrl_c;
  logic             wr_period_c;
  logic [8:0]       rd_chain_c [NUM_DIGITS+1];
  logic [31:0]      rd_data_c;
  logic [SEG_W-1:0] seg_next_c;

  assign wr_ctrl_c   = avs_write && (avs_address == ADDR_CTRL);
  assign wr_period_c = avs_write && (avs_address == ADDR_PERIOD);

  function automatic logic [6:0] hex_dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign rd_chain_c[0] = 9'd0;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [7:0] img_c;

    // Digit register; only its own word address selects it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        digit_q[g] <= 9'd0;
      end else if (avs_write && (avs_address == 4'(g))) begin
        digit_q[g] <= avs_writedata[8:0];
      end
    end

    always_comb begin
      img_c = digit_q[g][8] ? digit_q[g][7:0] : {digit_q[g][7], hex_dec(digit_q[g][3:0])};
      if (!en_q || blank_q[g] || (blink_q[g] && !phase_q)) begin
        img_c = 8'h00;
      end
    end

    assign seg_next_c[g*8 +: 8] = SEG_ACTIVE_LOW ? ~img_c : img_c;
    assign rd_chain_c[g+1]      = rd_chain_c[g] | ((avs_address == 4'(g)) ? digit_q[g] : 9'd0);
  end

  // Control and period registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q  <= 8'd0;
      blink_q  <= 8'd0;
      en_q     <= 1'b0;
      period_q <= BLINK_DIV;
    end else begin
      if (wr_ctrl_c) begin
        blank_q <= avs_writedata[7:0];
        blink_q <= avs_writedata[15:8];
        en_q    <= avs_writedata[16];
      end
      if (wr_period_c) begin
        period_q <= avs_writedata;
      end
    end
  end

  // Blink phase counter; a PERIOD write restarts the count without touching the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 32'd0;
      phase_q <= 1'b1;
    end else if (wr_period_c) begin
      cnt_q   <= 32'd0;
    end else if (period_q == 32'd0) begin
      cnt_q   <= 32'd0;
      phase_q <= 1'b1;
    end else if (cnt_q >= (period_q - 32'd1)) begin
      cnt_q   <= 32'd0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    rd_data_c = {23'd0, rd_chain_c[NUM_DIGITS]};
    case (avs_address)
      ADDR_CTRL:   rd_data_c = {15'd0, en_q, blink_q, blank_q};
      ADDR_PERIOD: rd_data_c = period_q;
      ADDR_STATUS: rd_data_c = {31'd0, phase_q};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      avs_readdata <= rd_data_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out <= SEG_OFF;
    end else begin
      seg_out <= seg_next_c;
    end
  end

endmodule
